// File: rtl/mcpu_pkg.sv
// Shared types and encodings for the multi-cycle RV32 subset core control path.
package mcpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_EXEC_I,
    S_EXEC_C,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_RTYPE   = 7'b0110011;
  localparam logic [6:0] OP_ITYPE   = 7'b0010011;
  localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BGT = 3'b101;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_CUSTOM = 2'b11;

  localparam logic       ADDR_PC     = 1'b0;
  localparam logic       ADDR_ALUOUT = 1'b1;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic       SRCA_PC  = 1'b0;
  localparam logic       SRCA_RS1 = 1'b1;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

endpackage

// File: rtl/mctrl_branch_eval.sv
// Branch condition evaluation from funct3 and the ALU flags of rs1 - rs2.
module mctrl_branch_eval
  import mcpu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_neg,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = alu_zero;
      F3_BGT:  taken = !alu_zero && !alu_neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32 subset core.
// Optional performance counters are built when MCTRL_PERF_EN is defined.
module multicycle_ctrl
  import mcpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        pc_init,
  output logic [1:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        halted
`ifdef MCTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_instret
`endif
);

  state_t state, next;
  logic   init_done;
  logic   br_taken;

  // RESET_PC is applied by the datapath; it is kept here for a single point of configuration.
  logic unused_reset_pc;
  assign unused_reset_pc = ^RESET_PC;

  mctrl_branch_eval u_branch_eval (
    .funct3   (funct3),
    .alu_zero (alu_zero),
    .alu_neg  (alu_neg),
    .taken    (br_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      init_done <= 1'b0;
    end else begin
      state     <= next;
      init_done <= 1'b1;
    end
  end

  // Qualified with rst_n so every output, including mem_req, drops the moment reset asserts.
  assign pc_init = rst_n & ~init_done;

  always_comb begin
    next         = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = ADDR_PC;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PCSRC_ALU;
    alu_op       = ALUOP_ADD;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    reg_we       = 1'b0;
    wb_sel       = WB_ALUOUT;
    halted       = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
            next  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM;
          case (opcode)
            OP_LOAD, OP_STORE: next = S_MEM_ADDR;
            OP_RTYPE:          next = S_EXEC_R;
            OP_ITYPE:          next = S_EXEC_I;
            OP_CUSTOM0:        next = S_EXEC_C;
            OP_BRANCH:         next = S_BRANCH;
            OP_JAL:            next = S_JAL;
            default:           next = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          next      = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_req      = 1'b1;
          mem_addr_sel = ADDR_ALUOUT;
          if (mem_ready) begin
            mdr_we = 1'b1;
            next   = S_MEM_WB;
          end
        end
        S_MEM_WB: begin
          reg_we = 1'b1;
          wb_sel = WB_MDR;
          next   = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req      = 1'b1;
          mem_we       = 1'b1;
          mem_addr_sel = ADDR_ALUOUT;
          if (mem_ready) next = S_FETCH;
        end
        S_EXEC_R: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_FUNCT;
          next      = S_ALU_WB;
        end
        S_EXEC_I: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_FUNCT;
          next      = S_ALU_WB;
        end
        S_EXEC_C: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_CUSTOM;
          next      = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_we = 1'b1;
          next   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_SUB;
          pc_src    = PCSRC_ALUOUT;
          pc_we     = br_taken;
          next      = S_FETCH;
        end
        S_JAL: begin
          reg_we = 1'b1;
          wb_sel = WB_PC;
          pc_we  = 1'b1;
          pc_src = PCSRC_ALUOUT;
          next   = S_FETCH;
        end
        S_HALT: halted = 1'b1;
        default: next = S_FETCH;
      endcase
    end
  end

`ifdef MCTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles  <= 32'd0;
      perf_instret <= 32'd0;
    end else begin
      if (state != S_HALT) perf_cycles <= perf_cycles + 32'd1;
      if (state != S_FETCH && next == S_FETCH) perf_instret <= perf_instret + 32'd1;
    end
  end
`endif

endmodule
